// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch port (I) and the load/store port (D).
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed D>I priority.

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic             grant_d;
  logic             lat_we;
  logic             pick_d;
  logic             any_req;
  logic [CNT_W-1:0] cnt;

  assign any_req = i_req | d_req;

`ifdef ARB_RR_EN
  logic last_i;

  // On contention the port that was not granted last wins; reset state is "I granted last".
  assign pick_d = d_req & (~i_req | last_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_i <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_i <= ~pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = lat_we ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The mem_* registers double as the latched request fields and are only nonzero during ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_d   <= 1'b0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d   <= pick_d;
            lat_we    <= pick_d & d_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : i_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            mem_wstrb <= pick_d ? d_wstrb : 4'b0000;
          end
        end
        ISSUE: begin
          if (!lat_we) cnt <= CNT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            if (grant_d) d_rdata <= mem_rdata;
            else         i_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign i_ack = (state == RESP) & ~grant_d;
  assign d_ack = (state == RESP) & grant_d;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model (honours ARB_RR_EN).

module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] memdata;
    int          exp_lat;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t        vecs [8];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          pend_cyc = -1;
  logic [31:0] pend_val;
  logic [31:0] env_mem [16];
  logic [31:0] golden [16];
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;

  // transaction-level reference model state
  bit          act;
  int          g_cyc;
  int          ack_cyc;
  int          free_at;
  bit          m_d;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic [3:0]  m_wstrb;
  bit          i_pend;
  bit          d_pend;
  bit          pick;
  bit          exp_men;
`ifdef ARB_RR_EN
  bit          last_i;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a & 32'hF000_003C;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance to the next falling edge and act as the fixed-latency memory.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_en && !mem_we) begin
      pend_cyc = cyc + MEM_LAT;
      pend_val = env_mem[mem_addr[5:2]];
    end
    if (mem_en && mem_we)
      env_mem[mem_addr[5:2]] = merge(env_mem[mem_addr[5:2]], mem_wdata, mem_wstrb);
    mem_rdata = (cyc == pend_cyc) ? pend_val : $urandom;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int          start;
    int          lat;
    int          n_en;
    logic        got;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    env_mem[v.addr[5:2]] = v.memdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    start = cyc; lat = -1; n_en = 0; got = 1'b0;
    c_we = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (mem_en) begin
        n_en++; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata; c_wstrb = mem_wstrb;
      end
      if ((v.is_d && d_ack) || (!v.is_d && i_ack)) begin
        got = 1'b1; lat = cyc - start; i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    if (!v.we) begin
      if (v.is_d) exp_d_rdata = v.memdata;
      else        exp_i_rdata = v.memdata;
    end
    check_output($sformatf("tbl%0d_latency", idx), lat, v.exp_lat);
    check_output($sformatf("tbl%0d_mem_en_count", idx), n_en, 1);
    check_output($sformatf("tbl%0d_mem_we", idx), 32'(c_we), 32'(v.we));
    check_output($sformatf("tbl%0d_mem_addr", idx), c_addr, v.addr);
    check_output($sformatf("tbl%0d_mem_wdata", idx), c_wdata, v.exp_wdata);
    check_output($sformatf("tbl%0d_mem_wstrb", idx), 32'(c_wstrb), 32'(v.exp_wstrb));
    check_output($sformatf("tbl%0d_i_rdata", idx), i_rdata, exp_i_rdata);
    check_output($sformatf("tbl%0d_d_rdata", idx), d_rdata, exp_d_rdata);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int       t_d;
    int       t_i;
    int       n_g;
    logic [2:0] gs;
    logic [2:0] gs_exp;
    logic     i_done;
    logic     d_on;
    logic     seen;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0010_0093, MEM_LAT+2, 32'h0, 4'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2, 32'hDEAD_BEEF, 4'b0011};
    vecs[2] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0, 32'h0BB0_C0DE, MEM_LAT+2, 32'h0, 4'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h1c09_0010, 32'h0, 4'h0, 32'hCAFE_F00D, MEM_LAT+2, 32'h0, 4'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_003c, 32'h0, 4'h0, 32'hA5A5_5A5A, MEM_LAT+2, 32'h0, 4'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0, 2, 32'h1122_3344, 4'b1111};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_001c, 32'h5566_7788, 4'b1000, 32'h0, 2, 32'h5566_7788, 4'b1000};
    vecs[7] = '{1'b0, 1'b0, 32'h1c09_0ffc, 32'h0, 4'h0, 32'h8000_0001, MEM_LAT+2, 32'h0, 4'h0};

    for (int i = 0; i < 16; i++) env_mem[i] = 32'h0;
    mem_rdata = 32'h0;

    // Reset held with both requests pending: everything stays quiet.
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_0014;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008; d_wdata = 32'h0; d_wstrb = 4'h0;
    env_mem[2] = 32'h0BAD_F00D;
    env_mem[5] = 32'h5EED_1234;
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("rst_ctrl", 32'({i_ack, d_ack, busy, mem_en, mem_we, mem_wstrb}), 32'h0);
      check_output("rst_mem_addr", mem_addr, 32'h0);
      check_output("rst_mem_wdata", mem_wdata, 32'h0);
      check_output("rst_i_rdata", i_rdata, 32'h0);
      check_output("rst_d_rdata", d_rdata, 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_output("rel_cycle1_idle", 32'({mem_en, busy}), 32'h0);
    tick();
    check_output("rel_cycle2_mem_en", 32'(mem_en), 32'h1);
    check_output("rel_first_grant_d", mem_addr, 32'h0000_0008);

    // Simultaneous requests: D load first, I follows after the RESP->IDLE bubble.
    t_d = -1; t_i = -1;
    for (int k = 0; k < 30 && (t_d < 0 || t_i < 0); k++) begin
      tick();
      if (d_ack && t_d < 0) begin t_d = cyc; d_req = 1'b0; end
      if (i_ack && t_i < 0) begin t_i = cyc; i_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check_output("cont_d_before_i", 32'(t_d >= 0 && t_i > t_d), 32'h1);
    check_output("cont_ack_gap", t_i - t_d, MEM_LAT + 3);
    check_output("cont_d_rdata", d_rdata, 32'h0BAD_F00D);
    check_output("cont_i_rdata", i_rdata, 32'h5EED_1234);
    exp_d_rdata = 32'h0BAD_F00D;
    exp_i_rdata = 32'h5EED_1234;
    tick();

    for (int v = 0; v < 8; v++) apply_stimulus(vecs[v], v);

    // Back-to-back stores on D with a fetch pending, starting from a fresh pointer.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_output("rr_rst_i_rdata", i_rdata, 32'h0);
    env_mem[9] = 32'h7777_8888;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0010; d_wdata = 32'h0F0F_0F0F; d_wstrb = 4'b0101;
    i_req = 1'b1; i_addr = 32'h0000_0024;
    n_g = 0; gs = 3'b000; i_done = 1'b0; d_on = 1'b1;
    for (int k = 0; k < 80 && (d_on || !i_done); k++) begin
      tick();
      if (mem_en && n_g < 3) begin gs[2-n_g] = mem_we; n_g++; end
      if (i_ack) begin i_done = 1'b1; i_req = 1'b0; end
      if (d_ack && n_g >= 3) begin d_req = 1'b0; d_on = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_RR_EN
    gs_exp = 3'b101;
`else
    gs_exp = 3'b111;
`endif
    check_output("rr_grant_order", 32'(gs), 32'(gs_exp));
    check_output("rr_i_served", 32'(i_done), 32'h1);
    check_output("rr_i_rdata", i_rdata, 32'h7777_8888);
    check_output("rr_d_rdata_unchanged", d_rdata, 32'h0);
    tick();

    // Reset while a fetch is in WAIT, with its read data still on its way.
    env_mem[12] = 32'h1234_5678;
    i_req = 1'b1; i_addr = 32'h0000_0030;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (mem_en) seen = 1'b1;
    end
    check_output("mw_issued", 32'(seen), 32'h1);
    tick();
    reset = 1'b0;
    i_req = 1'b0;
    #1;
    check_output("mw_idle_now", 32'({busy, i_ack, d_ack, mem_en}), 32'h0);
    check_output("mw_i_rdata", i_rdata, 32'h0);
    check_output("mw_d_rdata", d_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) reset = 1'b1;
      check_output("mw_no_ack", 32'({busy, i_ack, d_ack, mem_en}), 32'h0);
      check_output("mw_i_rdata_hold", i_rdata, 32'h0);
    end

    // Randomized traffic against the transaction-level model.
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = $urandom;
      golden[i]  = env_mem[i];
    end
    act = 1'b0; free_at = cyc; i_pend = 1'b0; d_pend = 1'b0;
    g_cyc = 0; ack_cyc = 0;
`ifdef ARB_RR_EN
    last_i = 1'b1;
`endif
    for (int k = 0; k < 3000; k++) begin
      tick();
      exp_men = act && (cyc == g_cyc + 1);
      if (act && cyc == ack_cyc && !m_we) begin
        if (m_d) exp_d_rdata = m_rdata;
        else     exp_i_rdata = m_rdata;
      end
      check_output("rnd_busy", 32'(busy), 32'(act && cyc > g_cyc && cyc <= ack_cyc));
      check_output("rnd_i_ack", 32'(i_ack), 32'(act && cyc == ack_cyc && !m_d));
      check_output("rnd_d_ack", 32'(d_ack), 32'(act && cyc == ack_cyc && m_d));
      check_output("rnd_mem_en", 32'(mem_en), 32'(exp_men));
      if (exp_men) begin
        check_output("rnd_mem_we", 32'(mem_we), 32'(m_we));
        check_output("rnd_mem_addr", mem_addr, m_addr);
        check_output("rnd_mem_wdata", mem_wdata, m_wdata);
        check_output("rnd_mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
      end else begin
        check_output("rnd_mem_quiet", mem_addr | mem_wdata | 32'({mem_we, mem_wstrb}), 32'h0);
      end
      check_output("rnd_i_rdata", i_rdata, exp_i_rdata);
      check_output("rnd_d_rdata", d_rdata, exp_d_rdata);
      if (act && cyc == ack_cyc) begin
        act = 1'b0;
        free_at = cyc + 1;
      end

      if (i_ack) i_pend = 1'b0;
      if (d_ack) d_pend = 1'b0;
      if (k < 2940) begin
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          i_pend = 1'b1; i_addr = rand_addr();
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend  = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = rand_addr();
          d_wdata = $urandom;
          d_wstrb = d_we ? 4'($urandom_range(0, 15)) : 4'h0;
        end
      end
      i_req = i_pend;
      d_req = d_pend;

      if (!act && cyc >= free_at && (i_pend || d_pend)) begin
`ifdef ARB_RR_EN
        pick   = d_pend && (!i_pend || last_i);
        last_i = !pick;
`else
        pick   = d_pend;
`endif
        act     = 1'b1;
        g_cyc   = cyc;
        m_d     = pick;
        m_we    = pick && d_we;
        m_addr  = pick ? d_addr : i_addr;
        m_wdata = pick ? d_wdata : 32'h0;
        m_wstrb = pick ? d_wstrb : 4'h0;
        ack_cyc = cyc + (m_we ? 2 : MEM_LAT + 2);
        if (m_we) golden[m_addr[5:2]] = merge(golden[m_addr[5:2]], m_wdata, m_wstrb);
        else      m_rdata = golden[m_addr[5:2]];
      end
    end
    check_output("rnd_drained", 32'({busy, i_req, d_req}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
